regfile_write_arbiter: RTL and testbench

Shares the single register-bank write port between the in-order pipeline writeback and the multi-cycle multiply/divide unit (MUU).
- Buffers MUU results in a small FIFO.
- Arbitrates with writeback priority and an anti-starvation FSM.
- Drives the bank's write_reg/write_data/write_enable/muu_write_enable from a registered output stage.
- Keeps a 32-bit scoreboard of MUU-pending destinations so the issue stage can stall on RAW hazards.

---
 rtl/regfile_arb_pkg.sv | 15 +
 rtl/regfile_write_arbiter_if.sv | 49 ++++
 rtl/regfile_arb_fifo.sv | 59 +++++
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file write arbiter.
package regfile_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wreg;
    logic [DATA_W-1:0]     data;
  } muu_entry_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Pipeline/MUU/bank signal bundle for regfile_write_arbiter.
// REGFILE_ARB_BYPASS_EN adds the forwarding outputs.
interface regfile_write_arbiter_if;
  import regfile_arb_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_ready;
  logic                  muu_issue;
  logic [REG_ADDR_W-1:0] muu_issue_reg;
  logic                  muu_valid;
  logic [REG_ADDR_W-1:0] muu_reg;
  logic [DATA_W-1:0]     muu_data;
  logic                  muu_ready;
  logic [REG_ADDR_W-1:0] query_reg1;
  logic [REG_ADDR_W-1:0] query_reg2;
  logic                  hazard;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic                  write_enable;
  logic                  muu_write_enable;
`ifdef REGFILE_ARB_BYPASS_EN
  logic                  bypass_valid1;
  logic                  bypass_valid2;
  logic [DATA_W-1:0]     bypass_data1;
  logic [DATA_W-1:0]     bypass_data2;
`endif

  modport slave (
    input  wb_valid, wb_reg, wb_data, muu_issue, muu_issue_reg,
    input  muu_valid, muu_reg, muu_data, query_reg1, query_reg2,
`ifdef REGFILE_ARB_BYPASS_EN
    output bypass_valid1, bypass_valid2, bypass_data1, bypass_data2,
`endif
    output wb_ready, muu_ready, hazard, write_reg, write_data,
    output write_enable, muu_write_enable
  );

  modport master (
    output wb_valid, wb_reg, wb_data, muu_issue, muu_issue_reg,
    output muu_valid, muu_reg, muu_data, query_reg1, query_reg2,
`ifdef REGFILE_ARB_BYPASS_EN
    input  bypass_valid1, bypass_valid2, bypass_data1, bypass_data2,
`endif
    input  wb_ready, muu_ready, hazard, write_reg, write_data,
    input  write_enable, muu_write_enable
  );
endinterface

// File: rtl/regfile_arb_fifo.sv
// Small synchronous FIFO buffering MUU results; pointers carry a wrap bit
// so full/empty need no separate counter.
module regfile_arb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  muu_entry_t din,
  output muu_entry_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  muu_entry_t    mem_q [DEPTH];
  muu_entry_t    mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-bank write port between pipeline writeback and the MUU.
// Optional REGFILE_ARB_BYPASS_EN forwards the output-stage write to the issue stage.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t            state_q, state_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic [31:0]           pending_q, pending_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic                  write_en_q, write_en_d;
  logic                  wb_ready;
  logic                  grant_wb, grant_fifo;
  logic                  fifo_full, fifo_empty, fifo_push;
  muu_entry_t            fifo_din, fifo_head, grant_entry;
  logic                  out_hit1, out_hit2;

  function automatic logic out_stage_hit(input logic                  vld,
                                         input logic [REG_ADDR_W-1:0] wreg,
                                         input logic [REG_ADDR_W-1:0] q);
    return vld && (wreg == q) && (q != '0);
  endfunction

  assign fifo_din  = '{wreg: bus.muu_reg, data: bus.muu_data};
  assign fifo_push = bus.muu_valid && !fifo_full;

  regfile_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (grant_fifo),
    .din     (fifo_din),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Arbitration: writeback wins in NORMAL; FORCE hands one slot to the FIFO.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    grant_wb     = 1'b0;
    grant_fifo   = 1'b0;
    wb_ready     = 1'b1;
    case (state_q)
      NORMAL: begin
        if (bus.wb_valid) begin
          grant_wb = 1'b1;
        end else if (!fifo_empty) begin
          grant_fifo = 1'b1;
        end
        if (fifo_empty || grant_fifo) begin
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
          if (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = FORCE;
        end
      end
      FORCE: begin
        wb_ready     = 1'b0;
        grant_fifo   = !fifo_empty;
        starve_cnt_d = '0;
        state_d      = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign grant_entry = grant_wb ? '{wreg: bus.wb_reg, data: bus.wb_data} : fifo_head;

  always_comb begin
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    pending_d    = pending_q;
    // Register 0 writes are consumed without ever reaching the bank.
    if ((grant_wb || grant_fifo) && (grant_entry.wreg != '0)) begin
      write_reg_d  = grant_entry.wreg;
      write_data_d = grant_entry.data;
      write_en_d   = 1'b1;
    end
    if (grant_fifo && (fifo_head.wreg != '0)) pending_d[fifo_head.wreg] = 1'b0;
    if (bus.muu_issue && (bus.muu_issue_reg != '0)) pending_d[bus.muu_issue_reg] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
      pending_q    <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      pending_q    <= pending_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      write_en_q   <= write_en_d;
    end
  end

  assign out_hit1 = out_stage_hit(write_en_q, write_reg_q, bus.query_reg1);
  assign out_hit2 = out_stage_hit(write_en_q, write_reg_q, bus.query_reg2);

  assign bus.wb_ready         = wb_ready;
  assign bus.muu_ready        = !fifo_full;
  assign bus.write_reg        = write_reg_q;
  assign bus.write_data       = write_data_q;
  assign bus.write_enable     = write_en_q;
  assign bus.muu_write_enable = write_en_q;

`ifdef REGFILE_ARB_BYPASS_EN
  assign bus.bypass_valid1 = out_hit1;
  assign bus.bypass_valid2 = out_hit2;
  assign bus.bypass_data1  = write_data_q;
  assign bus.bypass_data2  = write_data_q;
  assign bus.hazard        = pending_q[bus.query_reg1] || pending_q[bus.query_reg2];
`else
  assign bus.hazard = pending_q[bus.query_reg1] || out_hit1 ||
                      pending_q[bus.query_reg2] || out_hit2;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected bank writes are queued per
// source as stimulus is driven and popped as the output stage presents them.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  muu_entry_t wb_q[$];
  muu_entry_t muu_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_muu_reg(input logic [4:0] r);
    return (r == 5'd7) || (r == 5'd9) || (r >= 5'd20 && r <= 5'd22);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.write_enable) begin
      muu_entry_t e;
      check_val("muu_we_follows", bus.muu_write_enable, 1'b1);
      if (is_muu_reg(bus.write_reg)) begin
        check_val("muu_q_nonempty", muu_q.size() != 0, 1'b1);
        if (muu_q.size() != 0) begin
          e = muu_q.pop_front();
          check_val("muu_wr_reg", bus.write_reg, e.wreg);
          check_val("muu_wr_data", bus.write_data, e.data);
        end
      end else begin
        check_val("wb_q_nonempty", wb_q.size() != 0, 1'b1);
        if (wb_q.size() != 0) begin
          e = wb_q.pop_front();
          check_val("wb_wr_reg", bus.write_reg, e.wreg);
          check_val("wb_wr_data", bus.write_data, e.data);
        end
      end
    end
  end

  initial begin
    int k;
    int mi;
    bit exp_rdy;
    bit exp_mr;
    muu_entry_t m [3];

    bus.wb_valid = 0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.muu_issue = 0; bus.muu_issue_reg = '0;
    bus.muu_valid = 0; bus.muu_reg = '0; bus.muu_data = '0;
    bus.query_reg1 = '0; bus.query_reg2 = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_we", bus.write_enable, 1'b0);
    check_val("rst_mwe", bus.muu_write_enable, 1'b0);
    check_val("rst_muu_ready", bus.muu_ready, 1'b1);
    check_val("rst_wb_ready", bus.wb_ready, 1'b1);
    check_val("rst_hazard", bus.hazard, 1'b0);
    check_val("rst_wreg", bus.write_reg, 5'd0);
    check_val("rst_wdata", bus.write_data, 32'd0);
    #2 reset_n = 1'b1;
    tick();

    // Writeback only
    bus.wb_valid = 1; bus.wb_reg = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    wb_q.push_back('{wreg: 5'd5, data: 32'hDEAD_BEEF});
    check_val("wb_ready_req", bus.wb_ready, 1'b1);
    tick();
    bus.wb_valid = 0;
    check_val("wb_wr_reg5", bus.write_reg, 5'd5);
    check_val("wb_ready_after", bus.wb_ready, 1'b1);
    tick();
    check_val("wb_we_drop", bus.write_enable, 1'b0);

    // Starvation: one MUU result against continuous writeback
    bus.muu_valid = 1; bus.muu_reg = 5'd7; bus.muu_data = 32'h1234_5678;
    muu_q.push_back('{wreg: 5'd7, data: 32'h1234_5678});
    k = 0;
    for (int c = 0; c < 7; c++) begin
      exp_rdy = (c != 5);
      bus.wb_valid = 1;
      bus.wb_reg   = 5'(10 + k);
      bus.wb_data  = 32'hA000_0000 + k;
      check_val($sformatf("starve_rdy_c%0d", c), bus.wb_ready, exp_rdy);
      if (c == 6) check_val("force_wr_reg7", bus.write_reg, 5'd7);
      if (exp_rdy) begin
        wb_q.push_back('{wreg: 5'(10 + k), data: 32'hA000_0000 + k});
        k++;
      end
      tick();
      bus.muu_valid = 0;
    end
    bus.wb_valid = 0;
    tick();
    tick();

    // Full FIFO: three MUU results while writeback saturates
    m[0] = '{wreg: 5'd20, data: 32'h0000_00B0};
    m[1] = '{wreg: 5'd21, data: 32'h0000_00B1};
    m[2] = '{wreg: 5'd22, data: 32'h0000_00B2};
    for (int i = 0; i < 3; i++) muu_q.push_back(m[i]);
    k = 0;
    mi = 0;
    for (int c = 0; c < 18; c++) begin
      exp_rdy = !(c == 5 || c == 10 || c == 15);
      exp_mr  = (c < 2) || (c == 6) || (c >= 11);
      bus.wb_valid = 1;
      bus.wb_reg   = 5'(10 + (k % 8));
      bus.wb_data  = 32'hC000_0000 + k;
      bus.muu_valid = (mi < 3);
      if (mi < 3) begin
        bus.muu_reg  = m[mi].wreg;
        bus.muu_data = m[mi].data;
      end
      check_val($sformatf("full_wb_rdy_c%0d", c), bus.wb_ready, exp_rdy);
      check_val($sformatf("full_muu_rdy_c%0d", c), bus.muu_ready, exp_mr);
      if (exp_rdy) begin
        wb_q.push_back('{wreg: 5'(10 + (k % 8)), data: 32'hC000_0000 + k});
        k++;
      end
      if (mi < 3 && bus.muu_ready) begin
        if (mi == 2) check_val("m2_accept_cycle", c, 6);
        mi++;
      end
      tick();
    end
    bus.wb_valid = 0;
    bus.muu_valid = 0;
    tick();
    tick();

    // Scoreboard hazard tracking
    bus.muu_issue = 1; bus.muu_issue_reg = 5'd9;
    bus.query_reg1 = 5'd9; bus.query_reg2 = 5'd0;
    #1;
    check_val("hz_before_edge", bus.hazard, 1'b0);
    tick();
    bus.muu_issue = 0;
    check_val("hz_set", bus.hazard, 1'b1);
    bus.query_reg1 = 5'd3; bus.query_reg2 = 5'd9;
    #1;
    check_val("hz_q2", bus.hazard, 1'b1);
    bus.query_reg1 = 5'd9; bus.query_reg2 = 5'd0;
    tick();
    check_val("hz_hold", bus.hazard, 1'b1);
    bus.muu_valid = 1; bus.muu_reg = 5'd9; bus.muu_data = 32'h9999_9999;
    muu_q.push_back('{wreg: 5'd9, data: 32'h9999_9999});
    tick();
    bus.muu_valid = 0;
    check_val("hz_in_fifo", bus.hazard, 1'b1);
    tick();
`ifdef REGFILE_ARB_BYPASS_EN
    check_val("hz_out_stage", bus.hazard, 1'b0);
    check_val("byp_valid1", bus.bypass_valid1, 1'b1);
    check_val("byp_data1", bus.bypass_data1, 32'h9999_9999);
`else
    check_val("hz_out_stage", bus.hazard, 1'b1);
`endif
    tick();
    check_val("hz_cleared", bus.hazard, 1'b0);
    bus.muu_issue = 1; bus.muu_issue_reg = 5'd0;
    bus.query_reg1 = 5'd0;
    tick();
    bus.muu_issue = 0;
    check_val("hz_reg0", bus.hazard, 1'b0);

    // Zero-register MUU result is popped but never written
    bus.muu_valid = 1; bus.muu_reg = 5'd0; bus.muu_data = 32'h5555_5555;
    tick();
    bus.muu_reg = 5'd21; bus.muu_data = 32'h2121_2121;
    muu_q.push_back('{wreg: 5'd21, data: 32'h2121_2121});
    tick();
    bus.muu_valid = 0;
    check_val("r0_we_low", bus.write_enable, 1'b0);
    tick();
    check_val("r0_next_wr", bus.write_reg, 5'd21);
    check_val("r0_hz", bus.hazard, 1'b0);
    tick();

    // Reset mid-traffic
    bus.wb_valid = 1; bus.wb_reg = 5'd12; bus.wb_data = 32'h0000_1200;
    bus.muu_valid = 1; bus.muu_reg = 5'd20; bus.muu_data = 32'h0000_2000;
    bus.muu_issue = 1; bus.muu_issue_reg = 5'd9; bus.query_reg1 = 5'd9;
    tick();
    bus.wb_valid = 0; bus.muu_valid = 0; bus.muu_issue = 0;
    check_val("pre_rst_we", bus.write_enable, 1'b1);
    check_val("pre_rst_hz", bus.hazard, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_val("mid_rst_we", bus.write_enable, 1'b0);
    check_val("mid_rst_mwe", bus.muu_write_enable, 1'b0);
    check_val("mid_rst_muu_ready", bus.muu_ready, 1'b1);
    check_val("mid_rst_wb_ready", bus.wb_ready, 1'b1);
    check_val("mid_rst_hz", bus.hazard, 1'b0);
    wb_q.delete();
    muu_q.delete();
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    check_val("post_rst_hz", bus.hazard, 1'b0);
    bus.wb_valid = 1; bus.wb_reg = 5'd11; bus.wb_data = 32'h0000_1111;
    wb_q.push_back('{wreg: 5'd11, data: 32'h0000_1111});
    tick();
    bus.wb_valid = 0;
    check_val("post_rst_first_wr", bus.write_reg, 5'd11);
    repeat (3) tick();

    check_val("wb_q_drained", wb_q.size(), 0);
    check_val("muu_q_drained", muu_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
